// File: rtl/seq_divider16.sv
// seq_divider16: multi-cycle restoring divider, one quotient bit per clock.
// start/busy/done handshake: start is sampled only in IDLE or DONE; busy is
// high while iterating; done pulses for one cycle when quotient/remainder/
// div_by_zero are valid. Results hold until the next accepted start.
// Optional feature: define DIV_SIGNED_EN to add the signed_op port for
// two's-complement division (sign fix-up at result load, same latency).
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;          // partial remainder
    logic [WIDTH-1:0] qs_q, qs_d;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // latched divisor (magnitude)
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] qs_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             q_neg;
    logic             r_neg;

    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_step = (cnt_q == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // Operand magnitudes and result sign flags for signed operation
    always_comb begin
        a_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d = signed_op && dividend[WIDTH-1];
        end
    end

    // Sign flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign q_neg = qneg_q;
    assign r_neg = rneg_q;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_neg = 1'b0;
    assign r_neg = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = (divisor == '0) ? S_ZERO : S_RUN;
                else        state_d = S_IDLE;
            end
            S_RUN:   if (last_step) state_d = S_DONE;
            S_ZERO:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // One restoring step: trial subtract in WIDTH+1 bits, MSB set means negative
    always_comb begin
        p_ext   = {p_q, qs_q[WIDTH-1]};
        trial   = p_ext - {1'b0, d_q};
        p_next  = trial[WIDTH] ? p_ext[WIDTH-1:0] : trial[WIDTH-1:0];
        qs_next = {qs_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Datapath next values: operand latch, iteration, result load
    always_comb begin
        p_d    = p_q;
        qs_d   = qs_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            p_d   = '0;
            qs_d  = a_mag;
            d_d   = b_mag;
            cnt_d = '0;
            dbz_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    p_d   = p_next;
                    qs_d  = qs_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        quot_d = q_neg ? -qs_next : qs_next;
                        rem_d  = r_neg ? -p_next  : p_next;
                    end
                end
                S_ZERO: begin
                    // qs_q still holds the dividend magnitude; restore its sign
                    quot_d = '1;
                    rem_d  = r_neg ? -qs_q : qs_q;
                    dbz_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= '0;
            qs_q   <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            qs_q   <= qs_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: scoreboard bench for seq_divider16.
// Expected {quotient, remainder, div_by_zero} is pushed when an operation is
// issued and popped when done pulses; latency and handshake checked inline.
module tb_seq_divider16;

    localparam int W  = 16;
    localparam int EW = 2 * W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIV_SIGNED_EN
    logic         signed_op;
`endif

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_checks = 0;
    int n_errors = 0;

    seq_divider16 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op  (signed_op),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare every done pulse against the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_quotient", 32'(quotient), 32'(mon_e[EW-1:W+1]));
                check("sb_remainder", 32'(remainder), 32'(mon_e[W:1]));
                check("sb_div_by_zero", 32'(div_by_zero), 32'(mon_e[0]));
            end
        end
    end

    // driver: present start for one edge, optionally push the model result
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input bit push);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ed;
        int           sa;
        int           sb;
        if (push) begin
            if (b == '0) begin
                eq = '1; er = a; ed = 1'b1;
            end else if (sgn) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
                eq = W'(sa / sb);
                er = W'(sa % sb);
                ed = 1'b0;
            end else begin
                eq = a / b; er = a % b; ed = 1'b0;
            end
            exp_q.push_back({eq, er, ed});
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        signed_op = sgn;
`endif
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // count cycles after acceptance until done, bounded
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end while (!done && lat < 64);
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input int exp_lat);
        int lat;
        int bn;
        issue(a, b, sgn, 1'b1);
        wait_done(lat, bn);
        check("latency", lat, exp_lat);
        check("busy_cycles", bn, (exp_lat == 17) ? 16 : 0);
    endtask

    initial begin
        int lat;
        int bn;
        int cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        // 100 / 7
        run_op(16'd100, 16'd7, 1'b0, 17);
        check("q_100_7", 32'(quotient), 32'd14);
        check("r_100_7", 32'(remainder), 32'd2);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);

        // FFFF / 1, then back-to-back 3 / 10 issued in the DONE cycle
        issue(16'hFFFF, 16'd1, 1'b0, 1'b1);
        wait_done(lat, bn);
        check("lat_ffff_1", lat, 17);
        check("q_ffff_1", 32'(quotient), 32'hFFFF);
        check("r_ffff_1", 32'(remainder), 32'd0);
        issue(16'd3, 16'd10, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_q_held", 32'(quotient), 32'hFFFF);
        wait_done(lat, bn);
        check("b2b_latency", lat + 1, 17);
        check("q_3_10", 32'(quotient), 32'd0);
        check("r_3_10", 32'(remainder), 32'd3);

        // divide by zero, then 20 / 4 clears the flag on acceptance
        run_op(16'd5, 16'd0, 1'b0, 2);
        check("dbz_set", 32'(div_by_zero), 32'd1);
        check("dbz_q", 32'(quotient), 32'hFFFF);
        check("dbz_r", 32'(remainder), 32'd5);
        issue(16'd20, 16'd4, 1'b0, 1'b1);
        @(negedge clk);
        check("dbz_cleared", 32'(div_by_zero), 32'd0);
        wait_done(lat, bn);
        check("lat_20_4", lat + 1, 17);

        // start during RUN is ignored
        issue(16'd1000, 16'd3, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd9; divisor = 16'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bn);
        check("ignored_start_latency", lat + 4, 17);
        check("q_1000_3", 32'(quotient), 32'd333);
        check("r_1000_3", 32'(remainder), 32'd1);

        // reset in the middle of a run
        issue(16'd1000, 16'd3, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("midrst_quiet", cnt, 0);

        // dividend of zero still takes full latency
        run_op(16'd0, 16'd5, 1'b0, 17);
        check("q_0_5", 32'(quotient), 32'd0);

`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'd2, 1'b1, 17);
        check("q_m7_2", 32'(quotient), 32'hFFFD);
        check("r_m7_2", 32'(remainder), 32'hFFFF);
        run_op(16'h8000, 16'hFFFF, 1'b1, 17);
        check("q_ovf", 32'(quotient), 32'h8000);
        check("r_ovf", 32'(remainder), 32'd0);
        check("dbz_ovf", 32'(div_by_zero), 32'd0);
        run_op(16'hFFF9, 16'd0, 1'b1, 2);
`endif

        // random operations, issued back-to-back
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom_range(0, 65535));
            if (i % 4 == 0)      rb = '0;
            else if (i % 2 == 1) rb = W'($urandom_range(1, 15));
            else                 rb = W'($urandom_range(1, 65535));
`ifdef DIV_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, (rb == '0) ? 2 : 17);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
